fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_req   : fetch side -> memory, request valid this cycle
//   imem_addr  : fetch side -> memory, 8-bit request address
//   imem_ready : memory -> fetch side, data returned this cycle (0 = wait)
//   imem_rdata : memory -> fetch side, instruction for imem_addr
// Modports: master = fetch stage, slave = instruction memory.
// ---------------------------------------------------------------------------
interface fetch_stage_if;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ready;
  logic [7:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch with a small {pc, instr} prefetch FIFO feeding the F/D
// latch. Requests instructions at the fetch PC, buffers returned words,
// stops on a HALT instruction (8'hFF) and restarts on an Execute redirect.
//
// Ports:
//   clk        : system clock, rising-edge
//   rst        : asynchronous, active-high reset
//   StallF     : hold instrF/pcF (FIFO head is not popped)
//   PCSrcE     : redirect from Execute, highest priority
//   PCTargetE  : redirect target PC
//   imem       : instruction-memory bus (fetch_stage_if.master)
//   instrF     : FIFO head instruction, 8'h00 bubble when empty
//   pcF        : PC of instrF, 8'h00 when empty
//   haltedF    : fetch has stopped on a HALT instruction
//
// Configuration macro FETCH_PREFETCH_EN:
//   defined   -> FIFO depth 2 (one word of prefetch behind the head)
//   undefined -> FIFO depth 1 (single holding register)
// ---------------------------------------------------------------------------
module fetch_stage (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 StallF,
  input  logic                 PCSrcE,
  input  logic [7:0]           PCTargetE,
  fetch_stage_if.master        imem,
  output logic [7:0]           instrF,
  output logic [7:0]           pcF,
  output logic                 haltedF
);

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int         CNT_W      = $clog2(DEPTH + 1);
  localparam logic [7:0] HALT_INSTR = 8'hFF;

  typedef enum logic {RUN, HALT} state_t;

  // Control state (reset)
  state_t             state_q, state_d;
  logic [7:0]         pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // FIFO storage (no reset; validity is tracked by cnt_q). Index 0 is head.
  logic [7:0]         fpc_q    [DEPTH];
  logic [7:0]         finstr_q [DEPTH];
  logic [7:0]         fpc_d    [DEPTH];
  logic [7:0]         finstr_d [DEPTH];

  logic               empty, full, pop, req, push;

  // Handshake decode
  always_comb begin
    empty = (cnt_q == '0);
    full  = (cnt_q == CNT_W'(DEPTH));
    pop   = !StallF && !empty;
    // A full FIFO may still accept a word when the head leaves this cycle.
    // rst gating kills a pending request as soon as reset is asserted.
    req   = (state_q == RUN) && !rst && !PCSrcE && (!full || pop);
    // Memory data is only accepted against an outstanding request, so
    // imem_ready during a redirect or in HALT is ignored.
    push  = req && imem.imem_ready;
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  assign instrF  = empty ? 8'h00 : finstr_q[0];
  assign pcF     = empty ? 8'h00 : fpc_q[0];
  assign haltedF = (state_q == HALT);

  // Control next state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (PCSrcE) begin
      // Redirect flushes everything, including wrong-path buffered words.
      state_d = RUN;
      pc_d    = PCTargetE;
      cnt_d   = '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
      if (push) begin
        pc_d = pc_q + 8'd1;
        if (imem.imem_rdata == HALT_INSTR) begin
          state_d = HALT;
        end
      end
    end
  end

  // FIFO data next state: shift toward head on pop, write behind the
  // surviving entries on push.
  always_comb begin : fifo_data_next
    int wr_idx;
    wr_idx = int'(cnt_q) - (pop ? 1 : 0);
    for (int i = 0; i < DEPTH; i++) begin
      fpc_d[i]    = fpc_q[i];
      finstr_d[i] = finstr_q[i];
    end
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        fpc_d[i]    = fpc_q[i+1];
        finstr_d[i] = finstr_q[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (i == wr_idx)) begin
        fpc_d[i]    = pc_q;
        finstr_d[i] = imem.imem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      fpc_q[i]    <= fpc_d[i];
      finstr_q[i] <= finstr_d[i];
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk;
  logic       rst;
  logic       StallF;
  logic       PCSrcE;
  logic [7:0] PCTargetE;
  logic [7:0] instrF;
  logic [7:0] pcF;
  logic       haltedF;

  fetch_stage_if bus();

  logic [7:0] mem [256];
  assign bus.imem_rdata = mem[bus.imem_addr];

  fetch_stage dut (
    .clk       (clk),
    .rst       (rst),
    .StallF    (StallF),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (bus),
    .instrF    (instrF),
    .pcF       (pcF),
    .haltedF   (haltedF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: queue of {pc, instr}, fetch PC, halted flag.
  logic [15:0] mq [$];
  logic [7:0]  m_pc;
  logic        m_halt;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},    {7'b0, bus.imem_req}, 8'h00);
    chk({tag, "_addr"},   bus.imem_addr,        8'h00);
    chk({tag, "_instrF"}, instrF,               8'h00);
    chk({tag, "_pcF"},    pcF,                  8'h00);
    chk({tag, "_halted"}, {7'b0, haltedF},      8'h00);
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc   = 8'h00;
    m_halt = 1'b0;
  endtask

  // One clock cycle: drive, check outputs mid-cycle against the model,
  // clock, then advance the model.
  task automatic step(input logic st, input logic src, input logic [7:0] tgt, input logic rdy);
    logic       exp_req;
    logic [7:0] exp_i;
    logic [7:0] exp_p;
    StallF         = st;
    PCSrcE         = src;
    PCTargetE      = tgt;
    bus.imem_ready = rdy;
    @(negedge clk);
    exp_req = !m_halt && !src && ((mq.size() < DEPTH) || (!st && mq.size() > 0));
    exp_i   = (mq.size() > 0) ? mq[0][7:0]  : 8'h00;
    exp_p   = (mq.size() > 0) ? mq[0][15:8] : 8'h00;
    chk("imem_req",  {7'b0, bus.imem_req}, {7'b0, exp_req});
    chk("imem_addr", bus.imem_addr,        m_pc);
    chk("instrF",    instrF,               exp_i);
    chk("pcF",       pcF,                  exp_p);
    chk("haltedF",   {7'b0, haltedF},      {7'b0, m_halt});
    @(posedge clk);
    if (src) begin
      mq.delete();
      m_pc   = tgt;
      m_halt = 1'b0;
    end else begin
      if (!st && mq.size() > 0) void'(mq.pop_front());
      if (exp_req && rdy) begin
        mq.push_back({m_pc, mem[m_pc]});
        if (mem[m_pc] == 8'hFF) m_halt = 1'b1;
        m_pc = m_pc + 8'd1;
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i * 7 + 3);
      if (mem[i] == 8'hFF) mem[i] = 8'h01;
    end
    mem[8'h20] = 8'hFF;

    rst            = 1'b1;
    StallF         = 1'b0;
    PCSrcE         = 1'b0;
    PCTargetE      = 8'h00;
    bus.imem_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Straight-line fetch from 00 with constant ready
    repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Stall with data at 03,04,05, then release
    step(1'b0, 1'b1, 8'h03, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (4) step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("stall_pcF_hold", pcF, 8'h03);
    chk("stall_req_stop", {7'b0, bus.imem_req}, 8'h00);
    repeat (4) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Fill FIFO under stall, then redirect to 40 with ready high
    repeat (3) step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'h40, 1'b1);
    chk("redir_instrF", instrF, 8'h00);
    chk("redir_pcF", pcF, 8'h00);
    chk("redir_addr", bus.imem_addr, 8'h40);
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Wait states at PC 10
    step(1'b0, 1'b1, 8'h10, 1'b0);
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("wait_addr", bus.imem_addr, 8'h10);
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);

    // HALT at PC 20, then resume at 00
    step(1'b0, 1'b1, 8'h1E, 1'b1);
    repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("halt_flag", {7'b0, haltedF}, 8'h01);
    chk("halt_req", {7'b0, bus.imem_req}, 8'h00);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("resume_flag", {7'b0, haltedF}, 8'h00);
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);

    // PC wrap from FE, then mid-stream reset
    step(1'b0, 1'b1, 8'hFE, 1'b1);
    repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1);
    rst = 1'b1;
    #2;
    chk_zero("mid_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero("mid_reset_hold");
    model_reset();
    rst = 1'b0;
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Randomized traffic against the model
    repeat (400) begin
      step($urandom_range(0, 9) < 3,
           $urandom_range(0, 19) == 0,
           8'($urandom),
           $urandom_range(0, 9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
